interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Interrupt-entry sequencer for the hmc-6502 core. It sits beside the control FSM and arbitrates between four sources: reset, NMI, BRK and IRQ. When one is taken, it freezes the FSM and drives the datapath through the five-cycle entry sequence: push PCH, push PCL, push P, fetch the vector low byte, fetch the vector high byte. It then returns control to the FSM at the vector target.

## Interface
Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RESET, 16'hFFFC, reset vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- ph1  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- nmi_b  in  1  NMI request, active-low, edge-triggered, already synchronous to ph1
- irq_b  in  1  IRQ request, active-low, level-sensitive
- p_i  in  1  current I flag (1 = IRQ masked)
- brk_req  in  1  BRK decoded; valid only together with last_cycle
- last_cycle  in  1  instruction boundary from the control FSM
- int_busy  out  1  sequencer owns the datapath; control FSM holds its state
- stack_wr  out  1  write push data to (0x01, SP)
- sp_dec  out  1  decrement SP at the end of this cycle
- addr_sel  out  2  00 none, 01 stack, 10 vector
- push_sel  out  2  00 PCH, 01 PCL, 10 P
- vec_addr  out  16  vector byte address for this cycle
- pc_ld_lo  out  1  load PCL from data bus
- pc_ld_hi  out  1  load PCH from data bus
- set_i  out  1  set the I flag
- b_flag  out  1  value of the B bit in the pushed P
- int_src  out  2  source being serviced: 00 RESET, 01 NMI, 10 BRK, 11 IRQ

## Operation
- States: HOLD, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
- Outputs are a Moore decode of the state, int_src and the hijack register. They hold steady for the whole cycle.
- HOLD:
  - Entered asynchronously whenever reset=0.
  - int_busy=1, int_src=RESET, all strobes 0, vec_addr=VEC_RESET.
  - The first rising edge with reset=1 moves to PUSH_PCH.
- IDLE: int_busy=0 and all strobes 0. On an edge where last_cycle=1, the sequencer goes to PUSH_PCH if a source is eligible, otherwise stays in IDLE.
- Boundary priority: BRK (brk_req) > NMI (pending) > IRQ (irq_b=0 and p_i=0). IRQ is not latched; if deasserted before a boundary it is lost.
- NMI pending (nmi_edge sub-module):
  - Set on any edge where the registered nmi_b was 1 and the current nmi_b is 0.
  - Cleared on the edge that enters VEC_LO with NMI as the vector.
  - If set and clear occur on the same edge, set wins.
- PUSH_PCH, PUSH_PCL, PUSH_P:
  - addr_sel=01, sp_dec=1, push_sel=00/01/10 respectively.
  - stack_wr=1, except 0 when int_src=RESET. Reset performs dummy pushes: SP still decrements three times.
- b_flag=1 only when int_src=BRK; otherwise 0.
- Hijack: on the edge into VEC_LO, if NMI is pending and int_src is BRK or IRQ, the vector becomes VEC_NMI. int_src stays unchanged and b_flag keeps its value.
- VEC_LO: addr_sel=10, vec_addr = selected vector, pc_ld_lo=1.
- VEC_HI: addr_sel=10, vec_addr = selected vector + 1, pc_ld_hi=1, set_i=1.
- After VEC_HI the sequencer always returns to IDLE.
- last_cycle and brk_req are ignored in every state except IDLE.

## Timing
- Boundary sampled at edge E: PUSH_PCH occupies cycle E+1, VEC_HI occupies E+5, and int_busy falls at E+6.
- int_busy is 1 from E+1 through E+5.
- Reset release at edge R: PUSH_PCH at R+1 and VEC_HI at R+5.
- Reset mid-sequence:
  - Immediate return to HOLD; all strobes drop asynchronously.
  - NMI pending cleared; the registered nmi_b is forced to 1.
- An NMI edge during the NMI's own VEC_LO or VEC_HI cycle stays pending. It is serviced at the next boundary after the first handler instruction completes.
- An NMI edge during PUSH_P of a BRK or IRQ is seen at the VEC_LO entry edge and hijacks.
- nmi_b held low does not retrigger; it needs a high→low transition.

## Structure
- Shared package cpu_pkg holds:
  - int_state_t enum (7 states)
  - int_src_t enum (RESET, NMI, BRK, IRQ)
  - addr_sel and push_sel encodings
  - default vector constants
- One sub-module, nmi_edge: input register, falling-edge detect and the pending flag with set-priority clear. Its inputs are ph1, reset, nmi_b and clr; its output is pending.
- The top level holds the state register, int_src register, hijack register and output decode.

## Test plan
- Reset release, 5 edges:
  - states PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
  - stack_wr never 1 and sp_dec 1 for three cycles.
  - vec_addr FFFC then FFFD; set_i only in the fifth cycle.
- irq_b=0, p_i=0, last_cycle pulse:
  - int_src=11 and b_flag=0.
  - three stack writes with push_sel 00,01,10.
  - vec_addr FFFE/FFFF; int_busy low 6 cycles after the pulse.
- irq_b=0 with p_i=1 at the boundary: stays IDLE and int_busy remains 0.
- brk_req+last_cycle, with an nmi_b falling edge during PUSH_PCL:
  - b_flag=1 and int_src=10.
  - vec_addr FFFA/FFFB; NMI pending clear afterwards.
- brk_req and NMI pending at the same boundary: BRK taken, then hijacked to FFFA.
- Reset asserted during PUSH_P: all strobes drop immediately and NMI pending is 0. After release, a full reset sequence runs.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the hmc-6502 interrupt-entry sequencer:
// state and source enums, datapath select encodings and default vectors.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_IDLE,
      ST_PUSH_PCH,
      ST_PUSH_PCL,
      ST_PUSH_P,
      ST_VEC_LO,
      ST_VEC_HI
   } int_state_t;

   typedef enum logic [1:0] {
      SRC_RESET = 2'b00,
      SRC_NMI   = 2'b01,
      SRC_BRK   = 2'b10,
      SRC_IRQ   = 2'b11
   } int_src_t;

   localparam logic [1:0] ADDR_NONE   = 2'b00;
   localparam logic [1:0] ADDR_STACK  = 2'b01;
   localparam logic [1:0] ADDR_VECTOR = 2'b10;

   localparam logic [1:0] PSEL_PCH = 2'b00;
   localparam logic [1:0] PSEL_PCL = 2'b01;
   localparam logic [1:0] PSEL_P   = 2'b10;

   localparam logic [15:0] DEF_VEC_NMI   = 16'hFFFA;
   localparam logic [15:0] DEF_VEC_RESET = 16'hFFFC;
   localparam logic [15:0] DEF_VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/nmi_edge.sv
// NMI falling-edge detector with a pending flag; a new edge on the same
// cycle as a clear keeps the flag set.
module nmi_edge
   import cpu_pkg::*;
(
   input  logic ph1,
   input  logic reset,
   input  logic nmi_b,
   input  logic clr,
   output logic pending
);

   logic r_nmiPrev;
   logic r_pending;
   logic w_fall;

   assign w_fall  = r_nmiPrev & ~nmi_b;
   // An edge arriving this cycle is already visible to the arbiter and hijack logic.
   assign pending = r_pending | w_fall;

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_nmiPrev <= 1'b1;
         r_pending <= 1'b0;
      end else begin
         r_nmiPrev <= nmi_b;
         r_pending <= w_fall | (r_pending & ~clr);
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt-entry sequencer: arbitrates reset/NMI/BRK/IRQ and walks the
// datapath through the three pushes and two vector fetches.
module interrupt_sequencer
   import cpu_pkg::*;
#(
   parameter logic [15:0] VEC_NMI   = DEF_VEC_NMI,
   parameter logic [15:0] VEC_RESET = DEF_VEC_RESET,
   parameter logic [15:0] VEC_IRQ   = DEF_VEC_IRQ
)
(
   input  logic        ph1,
   input  logic        reset,
   input  logic        nmi_b,
   input  logic        irq_b,
   input  logic        p_i,
   input  logic        brk_req,
   input  logic        last_cycle,
   output logic        int_busy,
   output logic        stack_wr,
   output logic        sp_dec,
   output logic [1:0]  addr_sel,
   output logic [1:0]  push_sel,
   output logic [15:0] vec_addr,
   output logic        pc_ld_lo,
   output logic        pc_ld_hi,
   output logic        set_i,
   output logic        b_flag,
   output logic [1:0]  int_src
);

   int_state_t  r_state;
   int_src_t    r_src;
   logic        r_hijack;
   logic        w_nmiPending;
   logic        w_hijack;
   logic        w_nmiClr;
   logic [15:0] w_vecBase;

   assign w_hijack  = w_nmiPending & ((r_src == SRC_BRK) | (r_src == SRC_IRQ));
   assign w_nmiClr  = (r_state == ST_PUSH_P) & ((r_src == SRC_NMI) | w_hijack);
   assign w_vecBase = ((r_src == SRC_NMI) || r_hijack) ? VEC_NMI :
                      (r_src == SRC_RESET)             ? VEC_RESET : VEC_IRQ;

   nmi_edge u_nmiEdge (
      .ph1     (ph1),
      .reset   (reset),
      .nmi_b   (nmi_b),
      .clr     (w_nmiClr),
      .pending (w_nmiPending)
   );

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_HOLD;
         r_src    <= SRC_RESET;
         r_hijack <= 1'b0;
      end else begin
         case (r_state)
            ST_HOLD:     r_state <= ST_PUSH_PCH;
            ST_IDLE: begin
               if (last_cycle) begin
                  if (brk_req) begin
                     r_src   <= SRC_BRK;
                     r_state <= ST_PUSH_PCH;
                  end else if (w_nmiPending) begin
                     r_src   <= SRC_NMI;
                     r_state <= ST_PUSH_PCH;
                  end else if (!irq_b && !p_i) begin
                     r_src   <= SRC_IRQ;
                     r_state <= ST_PUSH_PCH;
                  end
               end
            end
            ST_PUSH_PCH: r_state <= ST_PUSH_PCL;
            ST_PUSH_PCL: r_state <= ST_PUSH_P;
            ST_PUSH_P: begin
               r_state  <= ST_VEC_LO;
               r_hijack <= w_hijack;
            end
            ST_VEC_LO:   r_state <= ST_VEC_HI;
            ST_VEC_HI:   r_state <= ST_IDLE;
            default:     r_state <= ST_IDLE;
         endcase
      end
   end

   // Reset entry performs dummy pushes: SP still walks down but nothing is written.
   always_comb begin
      int_busy = 1'b1;
      stack_wr = 1'b0;
      sp_dec   = 1'b0;
      addr_sel = ADDR_NONE;
      push_sel = PSEL_PCH;
      vec_addr = 16'h0000;
      pc_ld_lo = 1'b0;
      pc_ld_hi = 1'b0;
      set_i    = 1'b0;
      case (r_state)
         ST_HOLD:     vec_addr = VEC_RESET;
         ST_IDLE:     int_busy = 1'b0;
         ST_PUSH_PCH: begin
            stack_wr = (r_src != SRC_RESET);
            sp_dec   = 1'b1;
            addr_sel = ADDR_STACK;
            push_sel = PSEL_PCH;
         end
         ST_PUSH_PCL: begin
            stack_wr = (r_src != SRC_RESET);
            sp_dec   = 1'b1;
            addr_sel = ADDR_STACK;
            push_sel = PSEL_PCL;
         end
         ST_PUSH_P: begin
            stack_wr = (r_src != SRC_RESET);
            sp_dec   = 1'b1;
            addr_sel = ADDR_STACK;
            push_sel = PSEL_P;
         end
         ST_VEC_LO: begin
            addr_sel = ADDR_VECTOR;
            vec_addr = w_vecBase;
            pc_ld_lo = 1'b1;
         end
         ST_VEC_HI: begin
            addr_sel = ADDR_VECTOR;
            vec_addr = w_vecBase + 16'd1;
            pc_ld_hi = 1'b1;
            set_i    = 1'b1;
         end
         default:     int_busy = 1'b0;
      endcase
   end

   assign int_src = r_src;
   assign b_flag  = (r_src == SRC_BRK);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: a hand-computed vector table,
// a few hand-written corner sequences and a randomized run against a model.
module tb_interrupt_sequencer;

   logic        ph1;
   logic        reset;
   logic        nmi_b;
   logic        irq_b;
   logic        p_i;
   logic        brk_req;
   logic        last_cycle;
   logic        int_busy;
   logic        stack_wr;
   logic        sp_dec;
   logic [1:0]  addr_sel;
   logic [1:0]  push_sel;
   logic [15:0] vec_addr;
   logic        pc_ld_lo;
   logic        pc_ld_hi;
   logic        set_i;
   logic        b_flag;
   logic [1:0]  int_src;

   int checks = 0;
   int errors = 0;

   // Reference model: position in the entry sequence (-1 held in reset,
   // 0 idle, 1..5 the five entry cycles), source, chosen vector and NMI latch.
   int          mStep;
   logic [1:0]  mSrc;
   logic [15:0] mVec;
   bit          mPend;
   bit          mPrev;

   typedef struct {
      string       name;
      logic        rst;
      logic        nmi;
      logic        irq;
      logic        p;
      logic        brk;
      logic        last;
      logic [28:0] exp;
   } vec_t;

   vec_t tbl[$];

   interrupt_sequencer dut (
      .ph1        (ph1),
      .reset      (reset),
      .nmi_b      (nmi_b),
      .irq_b      (irq_b),
      .p_i        (p_i),
      .brk_req    (brk_req),
      .last_cycle (last_cycle),
      .int_busy   (int_busy),
      .stack_wr   (stack_wr),
      .sp_dec     (sp_dec),
      .addr_sel   (addr_sel),
      .push_sel   (push_sel),
      .vec_addr   (vec_addr),
      .pc_ld_lo   (pc_ld_lo),
      .pc_ld_hi   (pc_ld_hi),
      .set_i      (set_i),
      .b_flag     (b_flag),
      .int_src    (int_src)
   );

   // Free-running single-phase clock.
   initial ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   function automatic logic [28:0] pack(bit busy, bit wr, bit dec, logic [1:0] asel,
                                        logic [1:0] psel, logic [15:0] va, bit lo,
                                        bit hi, bit si, bit bf, logic [1:0] src);
      return {busy, wr, dec, asel, psel, va, lo, hi, si, bf, src};
   endfunction

   function automatic logic [28:0] dutPack();
      return {int_busy, stack_wr, sp_dec, addr_sel, push_sel, vec_addr,
              pc_ld_lo, pc_ld_hi, set_i, b_flag, int_src};
   endfunction

   function automatic logic [28:0] modelExpect();
      logic [28:0] e;
      if (mStep < 0)
         e = pack(1, 0, 0, 2'b00, 2'b00, 16'hFFFC, 0, 0, 0, 0, 2'b00);
      else if (mStep == 0)
         e = pack(0, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, 0, mSrc == 2'b10, mSrc);
      else if (mStep <= 3)
         e = pack(1, mSrc != 2'b00, 1, 2'b01, 2'(mStep - 1), 16'h0000, 0, 0, 0,
                  mSrc == 2'b10, mSrc);
      else if (mStep == 4)
         e = pack(1, 0, 0, 2'b10, 2'b00, mVec, 1, 0, 0, mSrc == 2'b10, mSrc);
      else
         e = pack(1, 0, 0, 2'b10, 2'b00, mVec + 16'd1, 0, 1, 1, mSrc == 2'b10, mSrc);
      return e;
   endfunction

   task automatic modelReset();
      mStep = -1;
      mSrc  = 2'b00;
      mVec  = 16'hFFFC;
      mPend = 1'b0;
      mPrev = 1'b1;
   endtask

   task automatic modelStep(input logic nmi, input logic irq, input logic p,
                            input logic brk, input logic last);
      bit fall;
      bit seen;
      bit clr;
      fall = mPrev && !nmi;
      seen = mPend || fall;
      clr  = 1'b0;
      if (mStep < 0) begin
         mStep = 1;
      end else if (mStep == 0) begin
         if (last) begin
            if (brk)              begin mSrc = 2'b10; mStep = 1; end
            else if (seen)        begin mSrc = 2'b01; mStep = 1; end
            else if (!irq && !p)  begin mSrc = 2'b11; mStep = 1; end
         end
      end else if (mStep == 3) begin
         if (mSrc == 2'b01 || (mSrc[1] && seen)) mVec = 16'hFFFA;
         else if (mSrc == 2'b00)                 mVec = 16'hFFFC;
         else                                    mVec = 16'hFFFE;
         clr   = (mVec == 16'hFFFA);
         mStep = 4;
      end else if (mStep == 5) begin
         mStep = 0;
      end else begin
         mStep = mStep + 1;
      end
      mPend = fall || (mPend && !clr);
      mPrev = nmi;
   endtask

   task automatic checkOutput(input string name, input logic [28:0] exp);
      logic [28:0] got;
      got    = dutPack();
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, step the model on
   // the rising edge, and return at the next falling edge for sampling.
   task automatic applyStimulus(input logic rst, input logic nmi, input logic irq,
                                input logic p, input logic brk, input logic last);
      reset      = rst;
      nmi_b      = nmi;
      irq_b      = irq;
      p_i        = p;
      brk_req    = brk;
      last_cycle = last;
      if (!rst) modelReset();
      @(posedge ph1);
      if (rst) modelStep(nmi, irq, p, brk, last);
      else     modelReset();
      @(negedge ph1);
   endtask

   task automatic addRow(input string name, input logic rst, input logic nmi,
                         input logic irq, input logic p, input logic brk,
                         input logic last, input logic [28:0] exp);
      vec_t v;
      v.name = name; v.rst = rst; v.nmi = nmi; v.irq = irq;
      v.p = p; v.brk = brk; v.last = last; v.exp = exp;
      tbl.push_back(v);
   endtask

   initial begin
      logic [28:0] holdExp;
      logic [28:0] idleBrk;
      logic        rNmi;
      holdExp = pack(1, 0, 0, 2'b00, 2'b00, 16'hFFFC, 0, 0, 0, 0, 2'b00);
      idleBrk = pack(0, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 1, 2'b10);

      addRow("rst_pch",  1, 1, 1, 1, 0, 0, pack(1, 0, 1, 2'b01, 2'b00, 16'h0, 0, 0, 0, 0, 2'b00));
      addRow("rst_pcl",  1, 1, 1, 1, 0, 0, pack(1, 0, 1, 2'b01, 2'b01, 16'h0, 0, 0, 0, 0, 2'b00));
      addRow("rst_p",    1, 1, 1, 1, 0, 0, pack(1, 0, 1, 2'b01, 2'b10, 16'h0, 0, 0, 0, 0, 2'b00));
      addRow("rst_vlo",  1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFC, 1, 0, 0, 0, 2'b00));
      addRow("rst_vhi",  1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFD, 0, 1, 1, 0, 2'b00));
      addRow("rst_idle", 1, 1, 1, 1, 0, 0, pack(0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0, 0, 0, 2'b00));
      addRow("irq_pch",  1, 1, 0, 0, 0, 1, pack(1, 1, 1, 2'b01, 2'b00, 16'h0, 0, 0, 0, 0, 2'b11));
      addRow("irq_pcl",  1, 1, 1, 1, 0, 0, pack(1, 1, 1, 2'b01, 2'b01, 16'h0, 0, 0, 0, 0, 2'b11));
      addRow("irq_p",    1, 1, 1, 1, 0, 0, pack(1, 1, 1, 2'b01, 2'b10, 16'h0, 0, 0, 0, 0, 2'b11));
      addRow("irq_vlo",  1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFE, 1, 0, 0, 0, 2'b11));
      addRow("irq_vhi",  1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFF, 0, 1, 1, 0, 2'b11));
      addRow("irq_done", 1, 1, 1, 1, 0, 0, pack(0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0, 0, 0, 2'b11));
      addRow("irq_mask", 1, 1, 0, 1, 0, 1, pack(0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0, 0, 0, 2'b11));
      addRow("brk_pch",  1, 1, 1, 1, 1, 1, pack(1, 1, 1, 2'b01, 2'b00, 16'h0, 0, 0, 0, 1, 2'b10));
      addRow("brk_pcl",  1, 1, 1, 1, 0, 0, pack(1, 1, 1, 2'b01, 2'b01, 16'h0, 0, 0, 0, 1, 2'b10));
      addRow("brk_p",    1, 0, 1, 1, 0, 0, pack(1, 1, 1, 2'b01, 2'b10, 16'h0, 0, 0, 0, 1, 2'b10));
      addRow("brk_hjlo", 1, 0, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFA, 1, 0, 0, 1, 2'b10));
      addRow("brk_hjhi", 1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFB, 0, 1, 1, 1, 2'b10));
      addRow("brk_done", 1, 1, 1, 1, 0, 0, idleBrk);
      addRow("nmi_clrd", 1, 1, 1, 1, 0, 1, idleBrk);
      addRow("nmi_set",  1, 0, 1, 1, 0, 0, idleBrk);
      addRow("bn_pch",   1, 1, 1, 1, 1, 1, pack(1, 1, 1, 2'b01, 2'b00, 16'h0, 0, 0, 0, 1, 2'b10));
      addRow("bn_pcl",   1, 1, 1, 1, 0, 0, pack(1, 1, 1, 2'b01, 2'b01, 16'h0, 0, 0, 0, 1, 2'b10));
      addRow("bn_p",     1, 1, 1, 1, 0, 0, pack(1, 1, 1, 2'b01, 2'b10, 16'h0, 0, 0, 0, 1, 2'b10));
      addRow("bn_vlo",   1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFA, 1, 0, 0, 1, 2'b10));
      addRow("bn_vhi",   1, 1, 1, 1, 0, 0, pack(1, 0, 0, 2'b10, 2'b00, 16'hFFFB, 0, 1, 1, 1, 2'b10));
      addRow("bn_done",  1, 1, 1, 1, 0, 0, idleBrk);
      addRow("bn_clrd",  1, 1, 1, 1, 0, 1, idleBrk);

      reset = 1'b0; nmi_b = 1'b1; irq_b = 1'b1; p_i = 1'b1;
      brk_req = 1'b0; last_cycle = 1'b0;
      modelReset();
      @(negedge ph1);
      @(negedge ph1);
      checkOutput("hold", holdExp);

      foreach (tbl[i]) begin
         applyStimulus(tbl[i].rst, tbl[i].nmi, tbl[i].irq, tbl[i].p, tbl[i].brk, tbl[i].last);
         checkOutput(tbl[i].name, tbl[i].exp);
         checkOutput({tbl[i].name, "_model"}, modelExpect());
      end

      // Reset asserted in the middle of an IRQ entry with an NMI pending.
      applyStimulus(1, 1, 0, 0, 0, 1);
      checkOutput("mid_pch", modelExpect());
      applyStimulus(1, 1, 1, 1, 0, 0);
      applyStimulus(1, 0, 1, 1, 0, 0);
      checkOutput("mid_p", modelExpect());
      nmi_b = 1'b1;
      reset = 1'b0;
      #1;
      modelReset();
      checkOutput("async_hold", holdExp);
      checks = checks + 1;
      if (dut.u_nmiEdge.r_pending !== 1'b0) begin
         errors = errors + 1;
         $display("[TB] FAIL nmi_pending_rst got %b expected 0", dut.u_nmiEdge.r_pending);
      end
      @(negedge ph1);
      applyStimulus(0, 1, 1, 1, 0, 0);
      checkOutput("hold_again", holdExp);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1, 1, 1, 1, 0, (k == 6));
         checkOutput($sformatf("rerst_%0d", k), modelExpect());
      end

      // NMI taken at a boundary, held low, then a fresh edge during VEC_LO.
      applyStimulus(1, 0, 1, 1, 0, 1);
      checkOutput("nmi_take", modelExpect());
      applyStimulus(1, 0, 1, 1, 0, 0);
      applyStimulus(1, 0, 1, 1, 0, 0);
      applyStimulus(1, 1, 1, 1, 0, 0);
      checkOutput("nmi_vlo", modelExpect());
      applyStimulus(1, 0, 1, 1, 0, 0);
      checkOutput("nmi_vhi", modelExpect());
      applyStimulus(1, 0, 1, 1, 0, 0);
      checkOutput("nmi_idle", modelExpect());
      applyStimulus(1, 0, 1, 1, 0, 1);
      checkOutput("nmi_retake", modelExpect());

      // Randomized run against the model, with occasional reset pulses.
      rNmi = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 5) == 0) rNmi = ~rNmi;
         applyStimulus($urandom_range(0, 79) != 0, rNmi, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) == 0);
         checkOutput("rand", modelExpect());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
